// File: rtl/equalize_pipeline.sv
// Histogram-equalizer back end: builds a 256-entry LUT from the CDF with a
// serial divider, then streams image words from m1 through the LUT into m4.
module equalize_pipeline #(
  parameter logic [14:0] ADDRESS_OF_LAST = 15'd3,
  parameter logic [19:0] TOTAL_PIXELS    = 20'd64,
  parameter int          CDF_WIDTH       = 20
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CDF_WIDTH-1:0] cdf_min,
  input  logic                 inputBaseOffset,
  output logic [15:0]          m2ReadAddr,
  input  logic [127:0]         m2ReadBus,
  output logic [15:0]          m1ReadAddr,
  input  logic [127:0]         m1ReadBus,
  output logic                 m4WE,
  output logic [15:0]          m4WriteAddr,
  output logic [127:0]         m4WriteBus,
  output logic                 done
);

  localparam int CW = CDF_WIDTH;
  localparam int NW = 28;
  localparam logic [CW-1:0] N = CW'(TOTAL_PIXELS);

  typedef enum logic [2:0] {
    IDLE, LUT_RD, LUT_CAP, LUT_DIV,
    LUT_WR, MAP_RD, MAP_DRAIN, DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cmin;
  logic [CW-1:0] denom;
  logic          base;
  logic [7:0]    v;
  logic [NW-1:0] num;
  logic [NW-1:0] quo;
  logic [CW-1:0] rem;
  logic [4:0]    cnt;
  logic          skip;
  logic [14:0]   w;
  logic          drain;
  logic          a1_v;
  logic [14:0]   a1_w;
  logic [127:0]  cap;
  logic [7:0]    lut [256];

  logic [CW-1:0] cdf;
  logic [CW-1:0] diff;
  logic [NW-1:0] num_init;
  logic [CW:0]   rsh;
  logic [CW:0]   sub;
  logic          ge;
  logic [7:0]    q_sat;
  logic          unused;

  assign cdf      = m2ReadBus[CW-1:0];
  assign diff     = cdf - cmin;
  assign num_init = NW'(diff) * NW'(255) + NW'(denom >> 1);
  assign rsh      = {rem, num[NW-1]};
  assign sub      = rsh - {1'b0, denom};
  assign ge       = (rsh >= {1'b0, denom});
  assign q_sat    = (|quo[NW-1:8]) ? 8'hFF : quo[7:0];
  assign unused   = ^m2ReadBus[127:CW];

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      m2ReadAddr  <= '0;
      m1ReadAddr  <= '0;
      m4WE        <= 1'b0;
      m4WriteAddr <= '0;
      done        <= 1'b0;
      cmin        <= '0;
      denom       <= '0;
      base        <= 1'b0;
      v           <= '0;
      num         <= '0;
      quo         <= '0;
      rem         <= '0;
      cnt         <= '0;
      skip        <= 1'b0;
      w           <= '0;
      drain       <= 1'b0;
      a1_v        <= 1'b0;
      a1_w        <= '0;
      cap         <= '0;
    end else begin
      // read/capture/write pipeline for the mapping phase
      a1_v        <= 1'b0;
      m4WE        <= a1_v;
      m4WriteAddr <= a1_v ? {base, a1_w} : 16'd0;
      if (a1_v) cap <= m1ReadBus;
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cmin       <= cdf_min;
            base       <= inputBaseOffset;
            denom      <= N - cdf_min;
            v          <= '0;
            m2ReadAddr <= '0;
            state      <= LUT_RD;
          end
        end
        LUT_RD: begin
          m2ReadAddr <= '0;
          state      <= LUT_CAP;
        end
        LUT_CAP: begin
          // skipped entries still run the divider to keep 31 cycles/entry
          skip  <= (cdf < cmin) || (denom == '0);
          num   <= num_init;
          rem   <= '0;
          quo   <= '0;
          cnt   <= '0;
          state <= LUT_DIV;
        end
        LUT_DIV: begin
          num <= {num[NW-2:0], 1'b0};
          quo <= {quo[NW-2:0], ge};
          rem <= ge ? sub[CW-1:0] : rsh[CW-1:0];
          if (cnt == 5'd27) state <= LUT_WR;
          else cnt <= cnt + 5'd1;
        end
        LUT_WR: begin
          lut[v] <= skip ? 8'd0 : q_sat;
          if (v == 8'hFF) begin
            w          <= '0;
            m1ReadAddr <= {base, 15'd0};
            state      <= MAP_RD;
          end else begin
            v          <= v + 8'd1;
            m2ReadAddr <= {8'd0, v + 8'd1};
            state      <= LUT_RD;
          end
        end
        MAP_RD: begin
          a1_v <= 1'b1;
          a1_w <= w;
          if (w == ADDRESS_OF_LAST) begin
            m1ReadAddr <= '0;
            drain      <= 1'b0;
            state      <= MAP_DRAIN;
          end else begin
            w          <= w + 15'd1;
            m1ReadAddr <= {base, w + 15'd1};
          end
        end
        MAP_DRAIN: begin
          if (drain) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            drain <= 1'b1;
          end
        end
        DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    m4WriteBus = '0;
    if (m4WE) begin
      for (int i = 0; i < 16; i++)
        m4WriteBus[8*i +: 8] = lut[cap[8*i +: 8]];
    end
  end

endmodule
